// File: rtl/dsp_mac_pipe_if.sv
// Signal bundle for the dsp_mac_pipe slice: clock enable, valid-tagged sample
// inputs, cascade input and the registered result/status outputs.
interface dsp_mac_pipe_if #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int P_WIDTH = 48
);
    logic                             i_ce;
    logic                             i_in_valid;
    logic signed [A_WIDTH-1:0]        i_a;
    logic signed [B_WIDTH-1:0]        i_b;
    logic signed [B_WIDTH-1:0]        i_d;
    logic signed [P_WIDTH-1:0]        i_c;
    logic signed [P_WIDTH-1:0]        i_pcin;
    logic        [4:0]                i_mode;
    logic                             i_acc_clr;
    logic                             o_out_valid;
    logic signed [P_WIDTH-1:0]        o_p;
    logic signed [P_WIDTH-1:0]        o_pcout;
    logic signed [A_WIDTH+B_WIDTH:0]  o_m;
    logic                             o_ovf;

    // Driver side (testbench or upstream logic).
    modport master (
        output i_ce, i_in_valid, i_a, i_b, i_d, i_c, i_pcin, i_mode, i_acc_clr,
        input  o_out_valid, o_p, o_pcout, o_m, o_ovf
    );

    // Slice side.
    modport slave (
        input  i_ce, i_in_valid, i_a, i_b, i_d, i_c, i_pcin, i_mode, i_acc_clr,
        output o_out_valid, o_p, o_pcout, o_m, o_ovf
    );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Signed multiply-accumulate slice: optional input delay line, pre-adder and
// multiplier stage (M), post-adder/accumulator stage (P) with saturation and a
// sticky overflow flag. Every stage advances only on the global clock enable.
module dsp_mac_pipe #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int P_WIDTH   = 48,
    parameter int IN_STAGES = 1,
    parameter int SATURATE  = 1
) (
    input logic            i_clk,
    input logic            i_rst,
    dsp_mac_pipe_if.slave  bus
);
    localparam int M_WIDTH = A_WIDTH + B_WIDTH + 1;
    localparam int S_WIDTH = P_WIDTH + 1;

    generate
        if (P_WIDTH < M_WIDTH) begin : g_bad_p_width
            $error("dsp_mac_pipe: P_WIDTH must be at least A_WIDTH+B_WIDTH+1");
        end
        if (IN_STAGES < 0 || IN_STAGES > 2) begin : g_bad_in_stages
            $error("dsp_mac_pipe: IN_STAGES must be 0, 1 or 2");
        end
    endgenerate

    // One sample as it travels through the input delay line; mode and C ride
    // with the data so each sample is processed with the mode it entered with.
    typedef struct packed {
        logic                      valid;
        logic                      acc_clr;
        logic [4:0]                mode;
        logic signed [P_WIDTH-1:0] c;
        logic signed [B_WIDTH-1:0] d;
        logic signed [B_WIDTH-1:0] b;
        logic signed [A_WIDTH-1:0] a;
    } sample_t;

    sample_t w_in;
    sample_t w_sin;

    assign w_in.valid   = bus.i_in_valid;
    assign w_in.acc_clr = bus.i_acc_clr;
    assign w_in.mode    = bus.i_mode;
    assign w_in.c       = bus.i_c;
    assign w_in.d       = bus.i_d;
    assign w_in.b       = bus.i_b;
    assign w_in.a       = bus.i_a;

    // ---------------- S_in: input delay line ----------------
    generate
        if (IN_STAGES == 0) begin : g_in_none
            assign w_sin = w_in;
        end else begin : g_in_regs
            sample_t r_in [IN_STAGES];

            // Shift the sample (data, mode and valid together) one stage per enabled cycle.
            // NOTE: every stage, data included, is cleared on reset because the reset state of all pipeline registers is observable.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < IN_STAGES; i++) begin
                        r_in[i] <= '0;
                    end
                end else if (bus.i_ce) begin
                    r_in[0] <= w_in;
                    for (int i = 1; i < IN_STAGES; i++) begin
                        r_in[i] <= r_in[i-1];
                    end
                end
            end

            assign w_sin = r_in[IN_STAGES-1];
        end
    endgenerate

    // ---------------- S_m: pre-adder and multiplier ----------------
    logic signed [B_WIDTH:0]   w_b_ext;
    logic signed [B_WIDTH:0]   w_d_ext;
    logic signed [B_WIDTH:0]   w_pre;
    logic signed [M_WIDTH-1:0] w_a_wide;
    logic signed [M_WIDTH-1:0] w_pre_wide;
    logic signed [M_WIDTH-1:0] w_prod;

    assign w_b_ext = {w_sin.b[B_WIDTH-1], w_sin.b};
    assign w_d_ext = {w_sin.d[B_WIDTH-1], w_sin.d};

    // Pre-adder: D+B, D-B, or B alone when the pre-adder is disabled.
    // NOTE: the default is assigned first so no path leaves w_pre unassigned and no latch is inferred.
    always_comb begin
        w_pre = w_b_ext;
        if (w_sin.mode[3]) begin
            w_pre = w_sin.mode[4] ? (w_d_ext - w_b_ext) : (w_d_ext + w_b_ext);
        end
    end

    // Operands widened to the full product width so the multiply is exact.
    assign w_a_wide   = M_WIDTH'(w_sin.a);
    assign w_pre_wide = M_WIDTH'(w_pre);
    assign w_prod     = w_a_wide * w_pre_wide;

    logic signed [M_WIDTH-1:0] r_m;
    logic signed [P_WIDTH-1:0] r_m_c;
    logic [2:0]                r_m_mode;
    logic                      r_m_clr;
    logic                      r_m_valid;

    // Product register; it loads on every enabled cycle, its value is don't-care for bubbles.
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m       <= '0;
            r_m_c     <= '0;
            r_m_mode  <= '0;
            r_m_clr   <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (bus.i_ce) begin
            r_m       <= w_prod;
            r_m_c     <= w_sin.c;
            r_m_mode  <= w_sin.mode[2:0];
            r_m_clr   <= w_sin.acc_clr;
            r_m_valid <= w_sin.valid;
        end
    end

    // ---------------- S_p: post-adder / accumulator ----------------
    logic signed [P_WIDTH-1:0] r_p;
    logic                      r_ovf;
    logic                      r_out_valid;

    logic signed [P_WIDTH-1:0] w_z;
    logic signed [S_WIDTH-1:0] w_z_wide;
    logic signed [S_WIDTH-1:0] w_m_wide;
    logic signed [S_WIDTH-1:0] w_sum;
    logic                      w_ovf;
    logic signed [P_WIDTH-1:0] w_res;

    localparam logic signed [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    // Z multiplexer; a block-start tag forces zero whatever the select says.
    always_comb begin
        w_z = '0;
        if (!r_m_clr) begin
            case (r_m_mode[1:0])
                2'b01:   w_z = r_p;
                2'b10:   w_z = r_m_c;
                2'b11:   w_z = bus.i_pcin;
                default: w_z = '0;
            endcase
        end
    end

    // One guard bit above P_WIDTH exposes overflow as a mismatch of the top two bits.
    assign w_z_wide = S_WIDTH'(w_z);
    assign w_m_wide = S_WIDTH'(r_m);
    assign w_sum    = r_m_mode[2] ? (w_z_wide - w_m_wide) : (w_z_wide + w_m_wide);
    assign w_ovf    = w_sum[P_WIDTH] ^ w_sum[P_WIDTH-1];

    // Clamp to the signed range on overflow when saturating, otherwise wrap.
    always_comb begin
        w_res = w_sum[P_WIDTH-1:0];
        if (w_ovf && (SATURATE != 0)) begin
            w_res = w_sum[P_WIDTH] ? P_MIN : P_MAX;
        end
    end

    // Result register and sticky overflow; bubbles leave both untouched.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p         <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (bus.i_ce) begin
            r_out_valid <= r_m_valid;
            if (r_m_valid) begin
                r_p   <= w_res;
                r_ovf <= r_m_clr ? w_ovf : (r_ovf | w_ovf);
            end
        end
    end

    assign bus.o_p         = r_p;
    assign bus.o_pcout     = r_p;
    assign bus.o_m         = r_m;
    assign bus.o_ovf       = r_ovf;
    assign bus.o_out_valid = r_out_valid;
endmodule
